// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: two read ports, one write port and a reservation port.
interface regfile_scoreboard_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_ok;
  logic            ready;

  // Requester side (pipeline / testbench)
  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ok, ready
  );

  // Register-file side
  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ok, ready
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write (busy) scoreboard.
// After reset the array is cleared one entry per cycle before the ports go live.
module regfile_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  localparam int unsigned NREGS = 1 << AW;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [AW-1:0]    cnt_q;
  logic [AW-1:0]    cnt_d;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic             live_c;
  logic             clear_en_c;
  logic             wr_fire_c;
  logic             rsv_ok_c;
  logic             rsv_fire_c;

  logic [AW-1:0]    rd_addr [2];
  logic [XLEN-1:0]  rd_data [2];
  logic             rd_busy [2];

  // State and clear-index register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk the clear index through every entry, then go live
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = S_READY;
      end
    end
  end

  // State decode
  always_comb begin
    live_c     = 1'b0;
    clear_en_c = 1'b0;
    if (state_q == S_READY) begin
      live_c = 1'b1;
    end else begin
      clear_en_c = 1'b1;
    end
  end

  // Write and reservation qualification; a same-cycle write to the target frees it
  always_comb begin
    wr_fire_c  = live_c & bus.wr_en & (bus.wr_addr != '0);
    rsv_ok_c   = live_c & bus.rsv_en &
                 ((bus.rsv_addr == '0) | ~busy_q[bus.rsv_addr] |
                  (bus.wr_en & (bus.wr_addr == bus.rsv_addr)));
    rsv_fire_c = rsv_ok_c & (bus.rsv_addr != '0);
  end

  // Busy next-state: write clears, reservation sets afterwards so it wins
  always_comb begin
    busy_d = busy_q;
    if (wr_fire_c) begin
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (rsv_fire_c) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Data array: cleared during init, written when live; a reset cycle drops the write
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_en_c) begin
        regs_q[cnt_q] <= '0;
      end else if (wr_fire_c) begin
        regs_q[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  assign rd_addr[0] = bus.rs1_addr;
  assign rd_addr[1] = bus.rs2_addr;

  // Combinational read ports with optional write forwarding; masked until live
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (live_c && (rd_addr[p] != '0)) begin
        if ((BYPASS != 0) && wr_fire_c && (bus.wr_addr == rd_addr[p])) begin
          rd_data[p] = bus.wr_data;
          rd_busy[p] = 1'b0;
        end else begin
          rd_data[p] = regs_q[rd_addr[p]];
          rd_busy[p] = busy_q[rd_addr[p]];
        end
      end
    end
  end

  assign bus.rs1_data = rd_data[0];
  assign bus.rs2_data = rd_data[1];
  assign bus.rs1_busy = rd_busy[0];
  assign bus.rs2_busy = rd_busy[1];
  assign bus.rsv_ok   = rsv_ok_c;
  assign bus.ready    = live_c;

endmodule
